// File: rtl/taillight_pkg.sv
// Shared state encoding for the tail-light sequencer.
// No timing or flow-control content; types only.
package taillight_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LSEQ,
        RSEQ,
        HAZ_ON,
        HAZ_OFF
    } state_t;

endpackage

// File: rtl/taillight_seq_tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks, first tick DIV clocks after reset release.
// Latency: tick is combinational from the counter register.
// Backpressure: none; free-running.
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/taillight_seq.sv
// Turn-signal / hazard tail-light sequencer for 2*LAMPS lamps.
// Latency: inputs sampled on a tick edge, y and busy update on that same edge.
// Backpressure: none; inputs between ticks are ignored, short pulses are not latched.
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
    output logic [2*LAMPS-1:0] y,
    output logic               busy
);

    localparam int SW = $clog2(LAMPS + 1);

    state_t             state, state_nxt;
    logic [SW-1:0]      step, step_nxt;
    logic [2*LAMPS-1:0] y_nxt;
    logic [LAMPS-1:0]   fill, fill_rev;
    logic               tick;
    logic               haz_req;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign haz_req = hazard | (left & right);

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE: begin
                if (haz_req) begin
                    state_nxt = HAZ_ON;
                end else if (left) begin
                    state_nxt = LSEQ;
                    step_nxt  = SW'(1);
                end else if (right) begin
                    state_nxt = RSEQ;
                    step_nxt  = SW'(1);
                end
            end
            // Sequences run to completion once started; only hazard aborts them.
            LSEQ, RSEQ: begin
                if (haz_req) begin
                    state_nxt = HAZ_ON;
                    step_nxt  = '0;
                end else if (step == SW'(LAMPS)) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                end else begin
                    step_nxt  = step + SW'(1);
                end
            end
            HAZ_ON:  state_nxt = HAZ_OFF;
            HAZ_OFF: state_nxt = haz_req ? HAZ_ON : IDLE;
            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
        endcase
    end

    // fill[i] lights the i-th lamp counted outward from the centre.
    always_comb begin
        fill     = '0;
        fill_rev = '0;
        for (int i = 0; i < LAMPS; i++) begin
            fill[i]               = (SW'(i) < step_nxt);
            fill_rev[LAMPS-1-i]   = (SW'(i) < step_nxt);
        end
    end

    always_comb begin
        y_nxt = '0;
        case (state_nxt)
            LSEQ:    y_nxt = {fill, {LAMPS{1'b0}}};
            RSEQ:    y_nxt = {{LAMPS{1'b0}}, fill_rev};
            HAZ_ON:  y_nxt = '1;
            default: y_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= '0;
            y     <= '0;
            busy  <= 1'b0;
        end else if (tick) begin
            state <= state_nxt;
            step  <= step_nxt;
            y     <= y_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_taillight_seq.sv
// Scoreboard bench: two sequencer instances (step every clock, and step every 4 clocks).
module tb_taillight_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, left1, right1, haz1, busy1;
    logic [5:0] y1;
    logic       rst4, left4, right4, haz4, busy4;
    logic [5:0] y4;

    taillight_seq #(.LAMPS(3), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(rst1), .left(left1), .right(right1),
        .hazard(haz1), .y(y1), .busy(busy1)
    );

    taillight_seq #(.LAMPS(3), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(rst4), .left(left4), .right(right4),
        .hazard(haz4), .y(y4), .busy(busy4)
    );

    typedef struct {
        logic [6:0] e;
        string      nm;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   ncmp = 0;
    int   nbad = 0;

    // Expected {busy, y} frames, y as LC LB LA RA RB RC.
    logic [6:0] lpat [4] = '{7'b1_001000, 7'b1_011000, 7'b1_111000, 7'b0_000000};
    logic [6:0] rpat [5] = '{7'b0_000000, 7'b1_000100, 7'b1_000110, 7'b1_000111, 7'b0_000000};

    function automatic void check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got busy=%b y=%b, want busy=%b y=%b",
                     nm, act[6], act[5:0], exp[6], exp[5:0]);
        end
    endfunction

    // Monitor: each expectation describes the outputs after the following rising edge.
    always @(negedge clk) begin
        exp_t t;
        if (q1.size() > 0) begin
            t = q1.pop_front();
            check(t.nm, {busy1, y1}, t.e);
        end
        if (q4.size() > 0) begin
            t = q4.pop_front();
            check(t.nm, {busy4, y4}, t.e);
        end
    end

    task automatic drv(input int sel, input logic l, input logic r, input logic h,
                       input logic rs, input logic [6:0] e, input string nm);
        exp_t t;
        @(negedge clk);
        #1;
        t.e  = e;
        t.nm = nm;
        if (sel == 1) begin
            left1 = l; right1 = r; haz1 = h; rst1 = rs;
            q1.push_back(t);
        end else begin
            left4 = l; right4 = r; haz4 = h; rst4 = rs;
            q4.push_back(t);
        end
    endtask

    initial begin
        rst1 = 1'b0; left1 = 1'b0; right1 = 1'b0; haz1 = 1'b0;
        rst4 = 1'b0; left4 = 1'b0; right4 = 1'b0; haz4 = 1'b0;

        drv(1, 0, 0, 0, 0, 7'b0_000000, "reset1");
        drv(4, 0, 0, 0, 0, 7'b0_000000, "reset4");

        // Left held for 10 ticks, then released mid-sequence.
        for (int i = 0; i < 10; i++) drv(1, 1, 0, 0, 1, lpat[i % 4], $sformatf("t1_left_%0d", i));
        drv(1, 0, 0, 0, 1, 7'b1_111000, "t1_finish");
        drv(1, 0, 0, 0, 1, 7'b0_000000, "t1_off");
        drv(1, 0, 0, 0, 1, 7'b0_000000, "t1_idle");

        // Single-tick left pulse completes the full animation.
        drv(1, 1, 0, 0, 1, 7'b1_001000, "t2_s1");
        drv(1, 0, 0, 0, 1, 7'b1_011000, "t2_s2");
        drv(1, 0, 0, 0, 1, 7'b1_111000, "t2_s3");
        drv(1, 0, 0, 0, 1, 7'b0_000000, "t2_off");
        drv(1, 0, 0, 0, 1, 7'b0_000000, "t2_idle");

        // Left and right together behave as hazard.
        drv(1, 1, 1, 0, 1, 7'b1_111111, "t3_on0");
        drv(1, 1, 1, 0, 1, 7'b1_000000, "t3_off0");
        drv(1, 1, 1, 0, 1, 7'b1_111111, "t3_on1");
        drv(1, 1, 1, 0, 1, 7'b1_000000, "t3_off1");
        drv(1, 1, 1, 0, 1, 7'b1_111111, "t3_on2");
        drv(1, 0, 0, 0, 1, 7'b1_000000, "t3_rel_off");
        drv(1, 0, 0, 0, 1, 7'b0_000000, "t3_rel_idle");

        // Hazard aborts a right sequence; left alone is ignored during a right sequence.
        drv(1, 0, 1, 0, 1, 7'b1_000100, "t4_r1");
        drv(1, 0, 1, 0, 1, 7'b1_000110, "t4_r2");
        drv(1, 0, 1, 1, 1, 7'b1_111111, "t4_abort");
        drv(1, 0, 0, 0, 1, 7'b1_000000, "t4_hazoff");
        drv(1, 0, 0, 0, 1, 7'b0_000000, "t4_idle");
        drv(1, 0, 1, 0, 1, 7'b1_000100, "t4b_r1");
        drv(1, 1, 0, 0, 1, 7'b1_000110, "t4b_r2_leftign");
        drv(1, 1, 0, 0, 1, 7'b1_000111, "t4b_r3_leftign");
        drv(1, 1, 0, 0, 1, 7'b0_000000, "t4b_end_idle");
        drv(1, 0, 0, 0, 1, 7'b0_000000, "t4b_stay");

        // Prescaled instance: right held, y moves exactly every 4 clocks.
        for (int i = 1; i <= 16; i++) drv(4, 0, 1, 0, 1, rpat[i / 4], $sformatf("t5_clk%0d", i));
        for (int i = 17; i <= 20; i++) drv(4, 0, 0, 0, 1, 7'b0_000000, $sformatf("t5_idle%0d", i));

        // Left to step 2, then asynchronous reset mid-sequence.
        for (int i = 21; i <= 28; i++)
            drv(4, 1, 0, 0, 1, (i < 24) ? 7'b0_000000 : ((i < 28) ? 7'b1_001000 : 7'b1_011000),
                $sformatf("t6_clk%0d", i));
        @(negedge clk);
        #1 rst4 = 1'b0;
        #1 check("t6_async_reset", {busy4, y4}, 7'b0_000000);
        drv(4, 1, 0, 0, 0, 7'b0_000000, "t6_hold0");
        drv(4, 1, 0, 0, 0, 7'b0_000000, "t6_hold1");
        for (int j = 1; j <= 4; j++)
            drv(4, 1, 0, 0, 1, (j < 4) ? 7'b0_000000 : 7'b1_001000, $sformatf("t6_rel%0d", j));
        for (int j = 5; j <= 8; j++)
            drv(4, 0, 0, 0, 1, (j < 8) ? 7'b1_001000 : 7'b1_011000, $sformatf("t6_run%0d", j));

        @(negedge clk);
        @(negedge clk);
        #1;
        if (q1.size() != 0 || q4.size() != 0) begin
            nbad++;
            $display("FAIL drain: q1=%0d q4=%0d entries left, want 0", q1.size(), q4.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
